// File: rtl/t07_mmio_responder.sv
// t07_mmio_responder: on-chip word memory answering the CPU memory handler.
// Each accepted request raises busy_o for LATENCY cycles, then spends one
// DONE cycle with busy_o low so the handler sees a falling edge. Requests
// are accepted only in IDLE.
module t07_mmio_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  rwi_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  sel_i,
    output logic        busy_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [1:0]  rwi_q;
    logic [29:0] idx_q;
    logic [31:0] wdata_q;
    logic [3:0]  sel_q;

    logic [31:0] mem [DEPTH];

    logic fire;
    logic in_range;
    logic do_write;

    // The access happens on the last ACCESS cycle, using only latched request fields
    always_comb begin
        fire     = (state == S_ACCESS) && (cnt == 4'd0);
        in_range = (idx_q < 30'(DEPTH));
        do_write = fire && (rwi_q == 2'b01) && in_range;
    end

    // Byte-lane masked write; the array is deliberately not reset
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_q[b]) mem[idx_q[AW-1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    // Control FSM with registered busy/rdata/err outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            rwi_q   <= 2'b00;
            idx_q   <= 30'd0;
            wdata_q <= 32'h0;
            sel_q   <= 4'h0;
            busy_o  <= 1'b0;
            rdata_o <= 32'h0;
            err_o   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    err_o <= 1'b0;
                    if (rwi_i != 2'b00) begin
                        rwi_q   <= rwi_i;
                        idx_q   <= addr_i[31:2];
                        wdata_q <= wdata_i;
                        sel_q   <= sel_i;
                        cnt     <= 4'(LATENCY - 1);
                        busy_o  <= 1'b1;
                        state   <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (cnt == 4'd0) begin
                        busy_o <= 1'b0;
                        state  <= S_DONE;
                        if (in_range) begin
                            if (rwi_q[1]) rdata_o <= mem[idx_q[AW-1:0]];
                        end else begin
                            // Out of range: write dropped, read/fetch yields zero
                            err_o <= 1'b1;
                            if (rwi_q[1]) rdata_o <= 32'h0;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    // One low-busy cycle; requests ignored here to avoid re-trigger
                    err_o <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    err_o  <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_t07_mmio_responder.sv
// Directed bench for t07_mmio_responder (DEPTH=256, LATENCY=2).
module tb_t07_mmio_responder;
    logic        clk;
    logic        rst;
    logic [1:0]  rwi_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  sel_i;
    logic        busy_o;
    logic [31:0] rdata_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    t07_mmio_responder #(.DEPTH(256), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .rwi_i(rwi_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .sel_i(sel_i), .busy_o(busy_o),
        .rdata_o(rdata_o), .err_o(err_o)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access with LATENCY=2: busy high two cycles, then DONE, then IDLE
    task automatic access(input string tag, input logic [1:0] rwi, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] sel,
                          output logic [31:0] rd, output logic e);
        @(negedge clk);
        rwi_i = rwi; addr_i = addr; wdata_i = wdata; sel_i = sel;
        @(posedge clk); #1;
        rwi_i = 2'b00; addr_i = 32'hFFFF_FFFC; wdata_i = 32'h0; sel_i = 4'h0;
        chk({tag, " busy c1"}, 32'(busy_o), 32'd1);
        @(posedge clk); #1;
        chk({tag, " busy c2"}, 32'(busy_o), 32'd1);
        @(posedge clk); #1;
        chk({tag, " busy done"}, 32'(busy_o), 32'd0);
        rd = rdata_o;
        e  = err_o;
        @(posedge clk); #1;
        chk({tag, " busy idle"}, 32'(busy_o), 32'd0);
        chk({tag, " err idle"}, 32'(err_o), 32'd0);
    endtask

    logic [31:0] rd;
    logic        e;

    initial begin
        rst = 1'b1; rwi_i = 2'b00; addr_i = 32'h0; wdata_i = 32'h0; sel_i = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy_o), 32'd0);
        chk("reset rdata", rdata_o, 32'h0);
        chk("reset err", 32'(err_o), 32'd0);
        @(negedge clk); rst = 1'b0;

        // Full-word write then read at 0x10
        access("wr10", 2'b01, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, rd, e);
        chk("wr10 err", 32'(e), 32'd0);
        chk("wr10 rdata kept", rd, 32'h0);
        access("rd10", 2'b10, 32'h0000_0010, 32'h0, 4'hF, rd, e);
        chk("rd10 data", rd, 32'hDEAD_BEEF);
        chk("rd10 err", 32'(e), 32'd0);

        // Byte-lane write on word 4, checked by fetch
        access("wr4", 2'b01, 32'h0000_0010, 32'h1122_3344, 4'hF, rd, e);
        chk("wr4 rdata kept", rd, 32'hDEAD_BEEF);
        access("wrb", 2'b01, 32'h0000_0010, 32'h0000_00AB, 4'b0001, rd, e);
        access("fe4", 2'b11, 32'h0000_0012, 32'h0, 4'hF, rd, e);
        chk("fe4 data", rd, 32'h1122_33AB);

        // Out of range at index 256
        access("wr0", 2'b01, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, rd, e);
        access("wroor", 2'b01, 32'h0000_0400, 32'hFFFF_FFFF, 4'hF, rd, e);
        chk("wroor err", 32'(e), 32'd1);
        chk("wroor rdata kept", rd, 32'h1122_33AB);
        access("rdoor", 2'b10, 32'h0000_0400, 32'h0, 4'hF, rd, e);
        chk("rdoor data", rd, 32'h0);
        chk("rdoor err", 32'(e), 32'd1);
        access("rd0", 2'b10, 32'h0000_0000, 32'h0, 4'hF, rd, e);
        chk("rd0 data", rd, 32'hCAFE_F00D);
        chk("rd0 err", 32'(e), 32'd0);

        // Reset during an in-flight write
        access("wr5", 2'b01, 32'h0000_0014, 32'hAAAA_5555, 4'hF, rd, e);
        access("rd5", 2'b10, 32'h0000_0014, 32'h0, 4'hF, rd, e);
        chk("rd5 data", rd, 32'hAAAA_5555);
        @(negedge clk);
        rwi_i = 2'b01; addr_i = 32'h0000_0014; wdata_i = 32'h1234_5678; sel_i = 4'hF;
        @(posedge clk); #1;
        rwi_i = 2'b00;
        chk("rst busy before", 32'(busy_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst busy", 32'(busy_o), 32'd0);
        chk("rst rdata", rdata_o, 32'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        access("rd5b", 2'b10, 32'h0000_0014, 32'h0, 4'hF, rd, e);
        chk("rd5 after rst", rd, 32'hAAAA_5555);

        // Held fetch request; address changes mid-ACCESS
        access("wr6", 2'b01, 32'h0000_0018, 32'h600D_0006, 4'hF, rd, e);
        access("wr7", 2'b01, 32'h0000_001C, 32'h7777_7777, 4'hF, rd, e);
        @(negedge clk);
        rwi_i = 2'b11; addr_i = 32'h0000_0018; sel_i = 4'hF;
        @(posedge clk); #1;
        addr_i = 32'h0000_001C;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            chk($sformatf("held busy c%0d", k), 32'(busy_o), ((k % 4) == 1 || (k % 4) == 2) ? 32'd1 : 32'd0);
            if (k == 3) chk("held fetch1", rdata_o, 32'h600D_0006);
            if (k == 7) chk("held fetch2", rdata_o, 32'h7777_7777);
        end
        rwi_i = 2'b00;
        @(posedge clk); #1;
        chk("held released", 32'(busy_o), 32'd0);
        chk("held rdata hold", rdata_o, 32'h7777_7777);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
